// File: rtl/wb_stage_buf_if.sv
// Handshake bundle between the MEM stage, the writeback buffer and the register file.
// "master" is the surrounding pipeline; "slave" is the stage buffer itself.
interface wb_stage_buf_if #(
  parameter int DATA_W  = 64,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [SEL_W-1:0]          in_sel;
  logic [NUM_SRC*DATA_W-1:0] in_src;
  logic [REG_AW-1:0]         in_rd;
  logic                      in_regwrite;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [REG_AW-1:0]         out_rd;
  logic                      out_regwrite;
  logic [REG_AW-1:0]         fwd_rs;
  logic                      fwd_hit;
  logic [DATA_W-1:0]         fwd_data;
  logic                      sel_err;
  logic [CNT_W-1:0]          retired_cnt;

  modport master (
    output flush, in_valid, in_sel, in_src, in_rd, in_regwrite, out_ready, fwd_rs,
    input  in_ready, out_valid, out_data, out_rd, out_regwrite, fwd_hit, fwd_data,
           sel_err, retired_cnt
  );

  modport slave (
    input  flush, in_valid, in_sel, in_src, in_rd, in_regwrite, out_ready, fwd_rs,
    output in_ready, out_valid, out_data, out_rd, out_regwrite, fwd_hit, fwd_data,
           sel_err, retired_cnt
  );
endinterface

// File: rtl/wb_stage_buf.sv
// Registered MEM/WB stage: N-way writeback source mux feeding a 2-entry elastic buffer
// toward the register-file write port, with flush, XZR suppression and forwarding lookup.
module wb_stage_buf #(
  parameter int DATA_W   = 64,
  parameter int NUM_SRC  = 4,
  parameter int SEL_W    = 2,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input logic          clk,
  input logic          reset,
  wb_stage_buf_if.slave bus
);
  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  // Slot 0 is the head (oldest); slot 1 is only valid while slot 0 is.
  logic [DATA_W-1:0] d0, d1;
  logic [REG_AW-1:0] rd0, rd1;
  logic              rw0, rw1;
  logic              v0, v1;
  logic              in_ready_q;
  logic              sel_err_q;
  logic [CNT_W-1:0]  ret_q;

  logic [DATA_W-1:0] mux_data;
  logic              sel_ok;
  logic              new_rw;
  logic              accept;
  logic              pop;
  logic              hit;
  logic [DATA_W-1:0] hit_data;

  always_comb begin
    mux_data = bus.in_src[DATA_W-1:0];
    sel_ok   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        mux_data = bus.in_src[k*DATA_W +: DATA_W];
        sel_ok   = 1'b1;
      end
    end
  end

  assign accept = bus.in_valid && in_ready_q;
  assign pop    = v0 && bus.out_ready;
  assign new_rw = bus.in_regwrite && (bus.in_rd != ZERO_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d0 <= '0; d1 <= '0; rd0 <= '0; rd1 <= '0;
      rw0 <= 1'b0; rw1 <= 1'b0; v0 <= 1'b0; v1 <= 1'b0;
      in_ready_q <= 1'b1;
      sel_err_q  <= 1'b0;
      ret_q      <= '0;
    end else begin
      sel_err_q <= accept && !sel_ok;
      if (bus.flush) begin
        v0 <= 1'b0; v1 <= 1'b0; rw0 <= 1'b0; rw1 <= 1'b0;
        in_ready_q <= 1'b1;
      end else begin
        if (pop && rw0 && ret_q != CNT_MAX) ret_q <= ret_q + 1'b1;
        case ({pop, accept})
          2'b11: begin
            if (v1) begin
              d0 <= d1; rd0 <= rd1; rw0 <= rw1;
              d1 <= mux_data; rd1 <= bus.in_rd; rw1 <= new_rw;
            end else begin
              d0 <= mux_data; rd0 <= bus.in_rd; rw0 <= new_rw;
            end
          end
          2'b10: begin
            // rw1 is kept clear while slot 1 is empty, so the head enable drops with it
            d0 <= d1; rd0 <= rd1; rw0 <= rw1; v0 <= v1;
            v1 <= 1'b0; rw1 <= 1'b0;
            in_ready_q <= 1'b1;
          end
          2'b01: begin
            if (!v0) begin
              d0 <= mux_data; rd0 <= bus.in_rd; rw0 <= new_rw; v0 <= 1'b1;
            end else begin
              d1 <= mux_data; rd1 <= bus.in_rd; rw1 <= new_rw; v1 <= 1'b1;
              in_ready_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    if (bus.fwd_rs != ZERO_IDX) begin
      if (v1 && rw1 && rd1 == bus.fwd_rs) begin
        hit      = 1'b1;
        hit_data = d1;
      end else if (v0 && rw0 && rd0 == bus.fwd_rs) begin
        hit      = 1'b1;
        hit_data = d0;
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = v0;
  assign bus.out_data     = d0;
  assign bus.out_rd       = rd0;
  assign bus.out_regwrite = rw0;
  assign bus.fwd_hit      = hit;
  assign bus.fwd_data     = hit_data;
  assign bus.sel_err      = sel_err_q;
  assign bus.retired_cnt  = ret_q;
endmodule

// File: tb/tb_wb_stage_buf.sv
// Bench for wb_stage_buf: directed scenario tasks plus a negedge scoreboard monitor
// that models occupancy, ordering, forwarding, sel_err and the saturating counter.
module tb_wb_stage_buf;
  localparam int DW = 64;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int AW = 5;
  localparam int ZR = 31;
  localparam int CW = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] rd;
    logic          rw;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests_run = 0;
  int   fails = 0;

  ent_t          sb[$];
  int            m_ret = 0;
  logic          m_selerr = 1'b0;
  ent_t          nent;
  logic          m_acc, m_pop, m_hit;
  logic [DW-1:0] m_fdata;
  logic [DW-1:0] srcw [NS];

  wb_stage_buf_if #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .REG_AW(AW), .CNT_W(CW)) bus ();

  wb_stage_buf #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .REG_AW(AW), .ZERO_REG(ZR), .CNT_W(CW))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Scoreboard: compare head on every cycle a pop is due, then advance the model.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      m_ret    = 0;
      m_selerr = 1'b0;
    end else begin
      tests_run++;
      if (bus.out_valid !== (sb.size() > 0)) begin
        fails++;
        $display("FAIL mon_out_valid: got %b want %b at %0t", bus.out_valid, sb.size() > 0, $time);
      end
      tests_run++;
      if (bus.in_ready !== (sb.size() < 2)) begin
        fails++;
        $display("FAIL mon_in_ready: got %b want %b at %0t", bus.in_ready, sb.size() < 2, $time);
      end
      tests_run++;
      if (bus.out_regwrite !== (sb.size() > 0 ? sb[0].rw : 1'b0)) begin
        fails++;
        $display("FAIL mon_out_regwrite: got %b at %0t", bus.out_regwrite, $time);
      end
      if (sb.size() > 0) begin
        tests_run++;
        if (bus.out_data !== sb[0].data || bus.out_rd !== sb[0].rd) begin
          fails++;
          $display("FAIL mon_head: got data %h rd %0d want data %h rd %0d at %0t",
                   bus.out_data, bus.out_rd, sb[0].data, sb[0].rd, $time);
        end
      end
      tests_run++;
      if (bus.retired_cnt !== CW'(m_ret)) begin
        fails++;
        $display("FAIL mon_retired: got %0d want %0d at %0t", bus.retired_cnt, m_ret, $time);
      end
      tests_run++;
      if (bus.sel_err !== m_selerr) begin
        fails++;
        $display("FAIL mon_sel_err: got %b want %b at %0t", bus.sel_err, m_selerr, $time);
      end
      m_hit   = 1'b0;
      m_fdata = '0;
      if (bus.fwd_rs != AW'(ZR)) begin
        foreach (sb[i]) begin
          if (sb[i].rw && sb[i].rd == bus.fwd_rs) begin
            m_hit   = 1'b1;
            m_fdata = sb[i].data;
          end
        end
      end
      tests_run++;
      if (bus.fwd_hit !== m_hit || bus.fwd_data !== m_fdata) begin
        fails++;
        $display("FAIL mon_fwd: got hit %b data %h want hit %b data %h at %0t",
                 bus.fwd_hit, bus.fwd_data, m_hit, m_fdata, $time);
      end

      m_acc = bus.in_valid && (sb.size() < 2);
      m_pop = (sb.size() > 0) && bus.out_ready;
      for (int k = 0; k < NS; k++) srcw[k] = bus.in_src[k*DW +: DW];
      nent.data = (int'(bus.in_sel) < NS) ? srcw[bus.in_sel] : srcw[0];
      nent.rd   = bus.in_rd;
      nent.rw   = bus.in_regwrite && (bus.in_rd != AW'(ZR));
      m_selerr  = m_acc && (int'(bus.in_sel) >= NS);
      if (bus.flush) begin
        sb.delete();
      end else begin
        if (m_pop) begin
          if (sb[0].rw && m_ret < (1 << CW) - 1) m_ret++;
          void'(sb.pop_front());
        end
        if (m_acc) sb.push_back(nent);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [SW-1:0] sel, input logic [DW-1:0] s0,
                         input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                         input logic [AW-1:0] rd, input logic rw);
    bus.in_valid    = 1'b1;
    bus.in_sel      = sel;
    bus.in_src      = {s2, s1, s0};
    bus.in_rd       = rd;
    bus.in_regwrite = rw;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic drain();
    idle();
    bus.out_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_sel = '0; bus.in_src = '0;
    bus.in_rd = '0; bus.in_regwrite = 1'b0; bus.out_ready = 1'b0; bus.fwd_rs = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_regwrite !== 1'b0 || bus.out_data !== '0 ||
        bus.out_rd !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid %b rw %b data %h rd %0d want all zero",
               bus.out_valid, bus.out_regwrite, bus.out_data, bus.out_rd);
    end
    tests_run++;
    if (bus.fwd_hit !== 1'b0 || bus.sel_err !== 1'b0 || bus.retired_cnt !== '0) begin
      fails++;
      $display("FAIL reset_misc: fwd_hit %b sel_err %b retired %0d want 0 0 0",
               bus.fwd_hit, bus.sel_err, bus.retired_cnt);
    end
    step();
    reset = 1'b1;
    step();
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    present(2'd1, 64'h0, 64'hDEAD_BEEF, 64'h0, 5'd3, 1'b1);
    step();
    idle();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hDEAD_BEEF || bus.out_rd !== 5'd3) begin
      fails++;
      $display("FAIL single_head: valid %b data %h rd %0d want 1 deadbeef 3",
               bus.out_valid, bus.out_data, bus.out_rd);
    end
    step();
    tests_run++;
    if (bus.retired_cnt !== 4'd1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_retire: retired %0d valid %b want 1 0", bus.retired_cnt, bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      present(2'd0, 64'h100 + 64'(r), 64'h0, 64'h0, AW'(r), 1'b1);
      step();
    end
    idle();
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.out_rd !== 5'd1) begin
      fails++;
      $display("FAIL bp_full: in_ready %b head rd %0d want 0 1", bus.in_ready, bus.out_rd);
    end
    bus.out_ready = 1'b1;
    step();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd2 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_second: valid %b rd %0d in_ready %b want 1 2 1",
               bus.out_valid, bus.out_rd, bus.in_ready);
    end
    drain();
    tests_run++;
    if (bus.retired_cnt !== 4'd3) begin
      fails++;
      $display("FAIL bp_retired: got %0d want 3", bus.retired_cnt);
    end
  endtask

  task automatic test_zero_reg();
    bus.out_ready = 1'b0;
    present(2'd0, 64'h5, 64'h0, 64'h0, 5'd31, 1'b1);
    step();
    idle();
    bus.fwd_rs = 5'd31;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_regwrite !== 1'b0 || bus.out_data !== 64'h5 ||
        bus.fwd_hit !== 1'b0) begin
      fails++;
      $display("FAIL zero_reg: valid %b rw %b data %h fwd_hit %b want 1 0 5 0",
               bus.out_valid, bus.out_regwrite, bus.out_data, bus.fwd_hit);
    end
    drain();
    tests_run++;
    if (bus.retired_cnt !== 4'd3) begin
      fails++;
      $display("FAIL zero_reg_retired: got %0d want 3", bus.retired_cnt);
    end
  endtask

  task automatic test_fwd_priority();
    bus.out_ready = 1'b0;
    present(2'd2, 64'h0, 64'h0, 64'h11, 5'd7, 1'b1);
    step();
    present(2'd2, 64'h0, 64'h0, 64'h22, 5'd7, 1'b1);
    step();
    idle();
    bus.fwd_rs = 5'd7;
    #1;
    tests_run++;
    if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 64'h22) begin
      fails++;
      $display("FAIL fwd_youngest: hit %b data %h want 1 22", bus.fwd_hit, bus.fwd_data);
    end
    bus.fwd_rs = 5'd8;
    #1;
    tests_run++;
    if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 64'h0) begin
      fails++;
      $display("FAIL fwd_miss: hit %b data %h want 0 0", bus.fwd_hit, bus.fwd_data);
    end
    bus.fwd_rs = 5'd7;
    drain();
    tests_run++;
    if (bus.retired_cnt !== 4'd5) begin
      fails++;
      $display("FAIL fwd_retired: got %0d want 5", bus.retired_cnt);
    end
  endtask

  task automatic test_illegal_sel();
    bus.out_ready = 1'b0;
    present(2'd3, 64'hAA, 64'hBB, 64'hCC, 5'd4, 1'b0);
    step();
    idle();
    tests_run++;
    if (bus.out_data !== 64'hAA || bus.sel_err !== 1'b1) begin
      fails++;
      $display("FAIL illegal_sel: data %h sel_err %b want aa 1", bus.out_data, bus.sel_err);
    end
    step();
    tests_run++;
    if (bus.sel_err !== 1'b0) begin
      fails++;
      $display("FAIL sel_err_pulse: got %b want 0", bus.sel_err);
    end
    drain();
  endtask

  task automatic test_flush_reset();
    bus.out_ready = 1'b0;
    present(2'd0, 64'h44, 64'h0, 64'h0, 5'd4, 1'b1);
    step();
    present(2'd0, 64'h55, 64'h0, 64'h0, 5'd5, 1'b1);
    step();
    present(2'd0, 64'h66, 64'h0, 64'h0, 5'd6, 1'b1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    idle();
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.retired_cnt !== 4'd5) begin
      fails++;
      $display("FAIL flush: valid %b in_ready %b retired %0d want 0 1 5",
               bus.out_valid, bus.in_ready, bus.retired_cnt);
    end
    bus.out_ready = 1'b0;
    present(2'd0, 64'h99, 64'h0, 64'h0, 5'd9, 1'b1);
    step();
    idle();
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_regwrite !== 1'b0 || bus.retired_cnt !== '0) begin
      fails++;
      $display("FAIL async_reset: valid %b rw %b retired %0d want 0 0 0",
               bus.out_valid, bus.out_regwrite, bus.retired_cnt);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] rd;
    for (int c = 0; c < 160; c++) begin
      rd = ($urandom_range(0, 7) == 0) ? AW'(ZR) : AW'($urandom_range(0, 6));
      present(SW'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, rd, ($urandom_range(0, 5) != 0));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.fwd_rs    = AW'($urandom_range(0, 7));
      bus.flush     = ($urandom_range(0, 40) == 0);
      step();
    end
    drain();
    tests_run++;
    if (bus.retired_cnt !== 4'hF) begin
      fails++;
      $display("FAIL saturate: got %0d want 15", bus.retired_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_zero_reg();
    test_fwd_priority();
    test_illegal_sel();
    test_flush_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
